prbs_lfsr_gen: RTL and testbench
================================

// Module: prbs_lfsr_gen
// PURPOSE
//  Parametrised Fibonacci LFSR pseudo-random generator with seed load, step enable,
//  all-zero lockup flag and a serial-to-word packer with valid/ready output.
//  Feeds PRBS stimulus words to datapath blocks and benches. The default configuration
//  reproduces the 153-bit x^153+x^152+1 sequence.
// PARAMETERS
//  WIDTH  153            LFSR state width, >=2
//  TAPS   (1<<152)|(1<<151)  feedback mask, WIDTH bits; bit WIDTH-1 must be set
//  SEED   4              reset/recovery state, WIDTH bits, must be non-zero
//  OUT_W  8              packed word width, 2..WIDTH
// PORTS
//  clk         in   1       clock, all state updates on posedge
//  rst         in   1       synchronous, active-high reset
//  ld          in   1       load din into LFSR state
//  din         in   WIDTH   load value
//  cnt_en      in   1       request one LFSR step this cycle
//  dout        out  WIDTH   current LFSR state (registered)
//  lockup      out  1       dout == 0 (combinational from state register)
//  word_valid  out  1       word_data holds an unaccepted word
//  word_ready  in   1       consumer accepts word_data this cycle
//  word_data   out  OUT_W   packed word; first-generated bit in MSB
// BEHAVIOUR
//  Reset: dout=SEED, word_valid=0, word_data=0, internal bit_cnt=0, word_sh=0.
//  Feedback: fb = ^(dout & TAPS). Step: dout <= {dout[WIDTH-2:0], fb}.
//  Each step shifts fb into word_sh at the LSB and increments bit_cnt.
//  Word complete: a step with bit_cnt==OUT_W-1 loads word_data <= {word_sh[OUT_W-2:0], fb},
//   sets word_valid=1 and bit_cnt=0. The word is visible 1 cycle after its OUT_W-th step.
//  Handshake: transfer when word_valid && word_ready. word_valid clears after a transfer,
//   except when a word completes in the same cycle; then it stays 1 with the new data.
//  Stall: step blocked when cnt_en && bit_cnt==OUT_W-1 && word_valid && !word_ready.
//   dout, bit_cnt and word_sh all hold. Steps with bit_cnt<OUT_W-1 continue under backpressure.
//  word_data/word_valid stay stable while stalled.
//  Priority: rst > ld > step. ld: dout<=din, bit_cnt<=0, word_sh<=0 (partial word dropped);
//   word_valid and word_data are untouched and a pending handshake completes normally.
//  cnt_en=0: no state change except the handshake.
//  All-zero state: fb=0, so the LFSR stays at 0; lockup=1 for as long as dout==0.
// CONFIGURATION
//  LFSR_LOCKUP_RECOVER_EN defined: an enabled, unstalled, non-ld cycle with dout==0 loads
//   dout<=SEED instead of stepping. It emits no bit and leaves bit_cnt unchanged.
//   lockup is high for exactly that one cycle.
//  Not defined: no recovery; the all-zero state persists until ld or rst; lockup is flag only.
// TESTING
//  1 rst then cnt_en=1 for 3 cycles (default params) -> dout 4, 8, 0x10, 0x20; lockup=0.
//  2 ld din=1<<151, then 2 steps -> dout=(1<<152)|1, then dout=3.
//  3 After test 2, word_ready=1, 6 more steps -> word_valid 1-cycle pulse, word_data=0xC0.
//  4 word_ready=0, cnt_en=1 held for 20 cycles -> word_valid=1 after step 8.
//    Steps 9-15 proceed, then dout frozen (bit_cnt=7).
//    Raise word_ready -> transfer and step 16 happen together; word_valid stays 1 with the new word.
//  5 ld din=0, cnt_en=1 -> lockup=1, dout stays 0.
//    With LFSR_LOCKUP_RECOVER_EN: next cycle dout=4, lockup=0, bit_cnt unchanged.
//  6 rst pulse mid-word (bit_cnt=5, word_valid=1) -> next cycle dout=4, word_valid=0,
//    word_data=0; the next word needs a full 8 steps.

Source files
------------

// File: rtl/prbs_lfsr_gen.sv
// rtl/prbs_lfsr_gen.sv - Fibonacci LFSR PRBS generator with seed load and valid/ready word packer
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (reload SEED out of the all-zero state)
module prbs_lfsr_gen #(
    parameter int               WIDTH = 153,
    parameter logic [WIDTH-1:0] TAPS  = {2'b11, {(WIDTH-2){1'b0}}},
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(4),
    parameter int               OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] dout,
    output logic             lockup,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [OUT_W-1:0] word_data
);

    localparam int              CW   = (OUT_W > 2) ? $clog2(OUT_W) : 1;
    localparam logic [CW-1:0]   LAST = CW'(OUT_W - 1);

    logic [CW-1:0]    bit_cnt;
    logic [OUT_W-2:0] word_sh;
    logic [OUT_W-1:0] sh_ext;
    logic             fb;
    logic             at_last;
    logic             xfer;
    logic             stall;
    logic             advance;
    logic             recover;
    logic             step;

    always_comb begin
        fb      = ^(dout & TAPS);
        lockup  = (dout == '0);
        at_last = (bit_cnt == LAST);
        xfer    = word_valid && word_ready;
        // Only the step that would overwrite an unaccepted word is held back.
        stall   = cnt_en && at_last && word_valid && !word_ready;
        advance = cnt_en && !ld && !stall;
`ifdef LFSR_LOCKUP_RECOVER_EN
        recover = advance && lockup;
`else
        recover = 1'b0;
`endif
        step    = advance && !recover;
        sh_ext  = {word_sh, fb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= SEED;
            bit_cnt    <= '0;
            word_sh    <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            if (xfer) begin
                word_valid <= 1'b0;
            end
            if (ld) begin
                dout    <= din;
                bit_cnt <= '0;
                word_sh <= '0;
            end else if (recover) begin
                dout <= SEED;
            end else if (step) begin
                dout    <= {dout[WIDTH-2:0], fb};
                word_sh <= sh_ext[OUT_W-2:0];
                if (at_last) begin
                    // A completing word wins over a same-cycle transfer clear.
                    word_data  <= sh_ext;
                    word_valid <= 1'b1;
                    bit_cnt    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// tb/tb_prbs_lfsr_gen.sv - directed + model-checked bench for prbs_lfsr_gen (default parameters)
module tb_prbs_lfsr_gen;

    localparam int W  = 153;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld = 1'b0;
    logic [W-1:0]  din = '0;
    logic          cnt_en = 1'b0;
    logic [W-1:0]  dout;
    logic          lockup;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic [OW-1:0] word_data;

    int checks = 0;
    int errors = 0;

    prbs_lfsr_gen dut (
        .clk(clk), .rst(rst), .ld(ld), .din(din), .cnt_en(cnt_en),
        .dout(dout), .lockup(lockup), .word_valid(word_valid),
        .word_ready(word_ready), .word_data(word_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: LFSR as a bit history (x^153+x^152+1), packer as a queue of emitted bits.
    logic [W-1:0]  m_dout;
    logic          m_valid;
    logic [OW-1:0] m_data;
    bit            m_bits[$];
    bit            model_ok = 0;

    always @(posedge clk) begin
        bit xfer, stall, b;
        if (rst) begin
            m_dout = W'(4); m_valid = 0; m_data = '0; m_bits.delete(); model_ok = 1;
        end else if (model_ok) begin
            xfer  = m_valid && word_ready;
            stall = cnt_en && m_bits.size() == OW - 1 && m_valid && !word_ready;
            if (xfer) m_valid = 0;
            if (ld) begin
                m_dout = din; m_bits.delete();
            end else if (cnt_en && !stall) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
                if (m_dout == '0) m_dout = W'(4);
                else begin
`else
                begin
`endif
                    b = m_dout[152] ^ m_dout[151];
                    m_dout = {m_dout[151:0], b};
                    m_bits.push_back(b);
                    if (m_bits.size() == OW) begin
                        m_data = '0;
                        foreach (m_bits[i]) m_data = {m_data[OW-2:0], m_bits[i]};
                        m_valid = 1;
                        m_bits.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_dout", dout, m_dout);
            check("model_lockup", W'(lockup), W'(m_dout == '0));
            check("model_valid", W'(word_valid), W'(m_valid));
            check("model_data", W'(word_data), W'(m_data));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] d15;
        logic [W-1:0] one = W'(1);

        // 1: reset then three steps
        cycle();
        check("rst_dout", dout, W'(4));
        check("rst_valid", W'(word_valid), '0);
        check("rst_data", W'(word_data), '0);
        check("rst_lockup", W'(lockup), '0);
        rst = 0; cnt_en = 1;
        cycle(); check("t1_step1", dout, W'(8));
        cycle(); check("t1_step2", dout, W'('h10));
        cycle(); check("t1_step3", dout, W'('h20));
        check("t1_lockup", W'(lockup), '0);

        // 2: load and two steps
        cnt_en = 0; ld = 1; din = one << 151;
        cycle(); ld = 0;
        check("t2_load", dout, one << 151);
        cnt_en = 1;
        cycle(); check("t2_step1", dout, (one << 152) | one);
        cycle(); check("t2_step2", dout, W'(3));

        // 3: six more steps complete word 0xC0, pulse with ready high
        word_ready = 1;
        repeat (6) cycle();
        check("t3_valid", W'(word_valid), W'(1));
        check("t3_data", W'(word_data), W'('hC0));
        cnt_en = 0;
        cycle(); check("t3_pulse_end", W'(word_valid), '0);

        // 4: backpressure stall and simultaneous transfer + completion
        word_ready = 0; cnt_en = 1; d15 = '0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (i == 7) check("t4_valid_before", W'(word_valid), '0);
            if (i == 8) check("t4_valid_step8", W'(word_valid), W'(1));
            if (i == 15) d15 = dout;
        end
        check("t4_dout15", d15, W'(3) << 21);
        check("t4_frozen", dout, W'(3) << 21);
        check("t4_valid_held", W'(word_valid), W'(1));
        word_ready = 1;
        cycle();
        check("t4_step16", dout, W'(3) << 22);
        check("t4_valid_kept", W'(word_valid), W'(1));
        cnt_en = 0;
        cycle(); check("t4_drained", W'(word_valid), '0);

        // 5: all-zero lockup
        ld = 1; din = '0; cnt_en = 1;
        cycle(); ld = 0;
        check("t5_zero", dout, '0);
        check("t5_lockup", W'(lockup), W'(1));
        cycle();
`ifdef LFSR_LOCKUP_RECOVER_EN
        check("t5_recover", dout, W'(4));
        check("t5_lockup_clear", W'(lockup), '0);
`else
        check("t5_stuck", dout, '0);
        check("t5_lockup_held", W'(lockup), W'(1));
`endif

        // random seed, random enable/ready, model-checked
        ld = 1;
        for (int k = 0; k < 5; k++) din = {din[W-33:0], 32'($urandom)};
        cycle(); ld = 0;
        for (int i = 0; i < 300; i++) begin
            cnt_en = ($urandom_range(0, 3) != 0);
            word_ready = ($urandom_range(0, 1) != 0);
            ld = ($urandom_range(0, 60) == 0);
            if (ld) for (int k = 0; k < 5; k++) din = {din[W-33:0], 32'($urandom)};
            cycle();
        end
        ld = 0;

        // 6: reset mid-word with a pending word
        cnt_en = 0; word_ready = 1;
        cycle();
        word_ready = 0; ld = 1; din = W'('h5A5A5A5A) | (one << 140);
        cycle(); ld = 0; cnt_en = 1;
        repeat (13) cycle();
        check("t6_valid_pending", W'(word_valid), W'(1));
        rst = 1;
        cycle();
        check("t6_rst_dout", dout, W'(4));
        check("t6_rst_valid", W'(word_valid), '0);
        check("t6_rst_data", W'(word_data), '0);
        rst = 0; word_ready = 1;
        repeat (7) cycle();
        check("t6_partial", W'(word_valid), '0);
        cycle();
        check("t6_full_word", W'(word_valid), W'(1));
        cnt_en = 0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
